pe_column_ctrl: RTL and testbench

Sequencer for one PE column: a systolic chain of O_CH binary PEs. Activations ripple one PE per cycle, and each PE accumulates output-stationary partial sums in an external accumulator. Per tile, the block reads activation and weight buffers, issues K steps of activations back-to-back, and generates per-PE accumulate-enable and clear strobes skewed to match the ripple. It then drains the chain and hands results to the output collector over a valid/ack handshake. It repeats this for a programmed number of tiles.

---
 rtl/pe_column_ctrl_if.sv | 44 ++++
 rtl/pe_column_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pe_column_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_column_ctrl_if.sv
// Handshake and buffer bus between the PE column sequencer and its
// surroundings: job control, buffer read strobes, per-PE accumulator
// strobes and the result handshake to the output collector.
interface pe_column_ctrl_if #(
  parameter int O_CH   = 64,
  parameter int CNT_W  = 8,
  parameter int TILE_W = 8
);

  logic              start_in;
  logic [CNT_W-1:0]  k_len_in;
  logic [TILE_W-1:0] tiles_in;
  logic              act_tile_rdy_in;
  logic              out_ack_in;

  logic              busy_out;
  logic              done_out;
  logic              act_rd_en_out;
  logic [CNT_W-1:0]  act_rd_addr_out;
  logic              act_gate_out;
  logic              w_rd_en_out;
  logic [CNT_W-1:0]  w_rd_addr_out;
  logic [O_CH-1:0]   acc_en_out;
  logic [O_CH-1:0]   acc_clr_out;
  logic              out_valid_out;
  logic [TILE_W-1:0] tile_idx_out;

  // Side that requests jobs, supplies tiles and collects results
  modport master (
    output start_in, k_len_in, tiles_in, act_tile_rdy_in, out_ack_in,
    input  busy_out, done_out, act_rd_en_out, act_rd_addr_out, act_gate_out,
           w_rd_en_out, w_rd_addr_out, acc_en_out, acc_clr_out,
           out_valid_out, tile_idx_out
  );

  // Sequencer side
  modport slave (
    input  start_in, k_len_in, tiles_in, act_tile_rdy_in, out_ack_in,
    output busy_out, done_out, act_rd_en_out, act_rd_addr_out, act_gate_out,
           w_rd_en_out, w_rd_addr_out, acc_en_out, acc_clr_out,
           out_valid_out, tile_idx_out
  );

endinterface

// File: rtl/pe_column_ctrl.sv
// Sequencer for one systolic PE column. Per tile it issues K back-to-back
// activation/weight reads, skews accumulate-enable and clear strobes down
// the column to follow the activation ripple, drains the chain and then
// presents the tile results to the collector until acknowledged.
module pe_column_ctrl #(
  parameter int O_CH   = 64,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 8,
  parameter int TILE_W = 8
) (
  input  logic clk_in,
  input  logic rst_in,
  pe_column_ctrl_if.slave bus
);

  // The skew chain must cover buffer latency plus the ripple to the last PE
  localparam int DEPTH = RD_LAT + O_CH - 1;
  localparam int DW    = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACT,
    STREAM,
    DRAIN,
    RESULT
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  kLen_q;
  logic [TILE_W-1:0] tiles_q;
  logic [CNT_W-1:0]  step_q;
  logic [DW-1:0]     drainCnt_q;
  logic [TILE_W-1:0] tile_q;
  logic              rdEn_q;
  logic              firstStep_q;
  logic              busy_q;
  logic              done_q;
  logic              valid_q;
  logic [DEPTH-1:0]  enSr_q;
  logic [DEPTH-1:0]  clrSr_q;

  logic [CNT_W-1:0]  kEff_d;
  logic [CNT_W-1:0]  kLast_d;
  logic [TILE_W-1:0] tileLast_d;

  // A zero step count would issue nothing, so it runs as a single step
  always_comb begin
    kEff_d     = (bus.k_len_in == '0) ? CNT_W'(1) : bus.k_len_in;
    kLast_d    = kLen_q - 1'b1;
    tileLast_d = tiles_q - 1'b1;
  end

  // Job/tile sequencing with all control outputs registered
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      kLen_q      <= '0;
      tiles_q     <= '0;
      step_q      <= '0;
      drainCnt_q  <= '0;
      tile_q      <= '0;
      rdEn_q      <= 1'b0;
      firstStep_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_in) begin
            kLen_q  <= kEff_d;
            tiles_q <= bus.tiles_in;
            tile_q  <= '0;
            if (bus.tiles_in == '0) begin
              done_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              state_q <= WAIT_ACT;
            end
          end
        end
        WAIT_ACT: begin
          if (bus.act_tile_rdy_in) begin
            rdEn_q      <= 1'b1;
            firstStep_q <= 1'b1;
            step_q      <= '0;
            state_q     <= STREAM;
          end
        end
        STREAM: begin
          firstStep_q <= 1'b0;
          if (step_q == kLast_d) begin
            rdEn_q     <= 1'b0;
            step_q     <= '0;
            drainCnt_q <= '0;
            state_q    <= DRAIN;
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        DRAIN: begin
          if (drainCnt_q == DW'(DEPTH - 1)) begin
            drainCnt_q <= '0;
            valid_q    <= 1'b1;
            state_q    <= RESULT;
          end else begin
            drainCnt_q <= drainCnt_q + 1'b1;
          end
        end
        RESULT: begin
          if (bus.out_ack_in) begin
            valid_q <= 1'b0;
            if (tile_q < tileLast_d) begin
              tile_q  <= tile_q + 1'b1;
              state_q <= WAIT_ACT;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          rdEn_q  <= 1'b0;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Skew chain: element i carries the (en, clr) pair issued i+1 cycles ago
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      enSr_q  <= '0;
      clrSr_q <= '0;
    end else begin
      enSr_q[0]  <= rdEn_q;
      clrSr_q[0] <= rdEn_q & firstStep_q;
      for (int i = 1; i < DEPTH; i++) begin
        enSr_q[i]  <= enSr_q[i-1];
        clrSr_q[i] <= clrSr_q[i-1];
      end
    end
  end

  assign bus.busy_out        = busy_q;
  assign bus.done_out        = done_q;
  assign bus.act_rd_en_out   = rdEn_q;
  assign bus.w_rd_en_out     = rdEn_q;
  assign bus.act_rd_addr_out = step_q;
  assign bus.w_rd_addr_out   = step_q;
  assign bus.act_gate_out    = enSr_q[RD_LAT-1];
  assign bus.acc_en_out      = enSr_q[DEPTH-1:RD_LAT-1];
  assign bus.acc_clr_out     = clrSr_q[DEPTH-1:RD_LAT-1];
  assign bus.out_valid_out   = valid_q;
  assign bus.tile_idx_out    = tile_q;

endmodule

// File: tb/tb_pe_column_ctrl.sv
// Directed bench for the PE column sequencer with a 4-PE column and
// single-cycle buffer latency.
module tb_pe_column_ctrl;

  localparam int O_CH   = 4;
  localparam int RD_LAT = 1;
  localparam int CNT_W  = 8;
  localparam int TILE_W = 8;
  localparam int DEPTH  = RD_LAT + O_CH - 1;

  logic clock = 1'b0;
  logic resetN;
  int   checks = 0;
  int   errors = 0;
  int   doneSeen = 0;
  int   doneBase;

  // Free-running 10-unit clock
  always #5 clock = ~clock;

  pe_column_ctrl_if #(.O_CH(O_CH), .CNT_W(CNT_W), .TILE_W(TILE_W)) bus ();

  pe_column_ctrl #(
    .O_CH(O_CH), .RD_LAT(RD_LAT), .CNT_W(CNT_W), .TILE_W(TILE_W)
  ) dut (
    .clk_in(clock),
    .rst_in(resetN),
    .bus(bus.slave)
  );

  // Tally done pulses, sampled away from the rising edge
  always @(negedge clock) begin
    if (bus.done_out === 1'b1) doneSeen++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input int kLen, input int tiles,
                               input logic rdy, input logic ack);
    bus.start_in        = start;
    bus.k_len_in        = CNT_W'(kLen);
    bus.tiles_in        = TILE_W'(tiles);
    bus.act_tile_rdy_in = rdy;
    bus.out_ack_in      = ack;
  endtask

  task automatic nextCycle();
    @(negedge clock);
    bus.start_in = 1'b0;
  endtask

  task automatic waitIssue(input int expectedWait, input string tag);
    int n;
    n = 0;
    do begin
      nextCycle();
      n++;
    end while (bus.act_rd_en_out !== 1'b1 && n < 100);
    checkOutput(tag, n, expectedWait);
  endtask

  // Called on the first issue cycle; walks to the first RESULT cycle
  task automatic checkTileWindow(input int kEff, input int tile, input int pokeAt);
    logic [O_CH-1:0] expEn;
    logic [O_CH-1:0] expClr;
    for (int o = 0; o <= kEff + DEPTH; o++) begin
      for (int k = 0; k < O_CH; k++) begin
        expEn[k]  = (o >= RD_LAT + k) && (o < RD_LAT + k + kEff);
        expClr[k] = (o == RD_LAT + k);
      end
      checkOutput($sformatf("rd_en t%0d o%0d", tile, o), bus.act_rd_en_out, o < kEff);
      checkOutput($sformatf("w_rd_en t%0d o%0d", tile, o), bus.w_rd_en_out, o < kEff);
      if (o < kEff) begin
        checkOutput($sformatf("rd_addr t%0d o%0d", tile, o), bus.act_rd_addr_out, o);
        checkOutput($sformatf("w_rd_addr t%0d o%0d", tile, o), bus.w_rd_addr_out, o);
      end
      checkOutput($sformatf("gate t%0d o%0d", tile, o), bus.act_gate_out,
                  (o >= RD_LAT) && (o < RD_LAT + kEff));
      checkOutput($sformatf("acc_en t%0d o%0d", tile, o), bus.acc_en_out, expEn);
      checkOutput($sformatf("acc_clr t%0d o%0d", tile, o), bus.acc_clr_out, expClr);
      checkOutput($sformatf("valid t%0d o%0d", tile, o), bus.out_valid_out, o == kEff + DEPTH);
      checkOutput($sformatf("busy t%0d o%0d", tile, o), bus.busy_out, 1);
      checkOutput($sformatf("tile_idx t%0d o%0d", tile, o), bus.tile_idx_out, tile);
      checkOutput($sformatf("done t%0d o%0d", tile, o), bus.done_out, 0);
      if (o < kEff + DEPTH) begin
        nextCycle();
        if (o == pokeAt) begin
          bus.start_in = 1'b1;
          bus.k_len_in = CNT_W'(7);
          bus.tiles_in = TILE_W'(5);
        end
      end
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " busy"}, bus.busy_out, 0);
    checkOutput({tag, " rd_en"}, bus.act_rd_en_out, 0);
    checkOutput({tag, " w_rd_en"}, bus.w_rd_en_out, 0);
    checkOutput({tag, " rd_addr"}, bus.act_rd_addr_out, 0);
    checkOutput({tag, " gate"}, bus.act_gate_out, 0);
    checkOutput({tag, " acc_en"}, bus.acc_en_out, 0);
    checkOutput({tag, " acc_clr"}, bus.acc_clr_out, 0);
    checkOutput({tag, " valid"}, bus.out_valid_out, 0);
  endtask

  // Acknowledge the last tile and expect the job to finish
  task automatic finishJob(input string tag);
    bus.out_ack_in = 1'b1;
    nextCycle();
    bus.out_ack_in = 1'b0;
    checkOutput({tag, " done"}, bus.done_out, 1);
    checkOutput({tag, " busy_after"}, bus.busy_out, 0);
    checkOutput({tag, " valid_after"}, bus.out_valid_out, 0);
    nextCycle();
    checkOutput({tag, " done_cleared"}, bus.done_out, 0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    #12;
    checkIdleOutputs("reset");
    checkOutput("reset done", bus.done_out, 0);
    checkOutput("reset tile_idx", bus.tile_idx_out, 0);
    @(negedge clock);
    resetN = 1'b1;
    nextCycle();

    // K=3, one tile, activations ready; ack held off for 5 cycles
    $display("[TB] basic tile K=3 T=1");
    applyStimulus(1'b1, 3, 1, 1'b1, 1'b0);
    waitIssue(2, "t1 issue_wait");
    checkTileWindow(3, 0, -1);
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      checkOutput($sformatf("t1 hold_valid %0d", i), bus.out_valid_out, 1);
      checkOutput($sformatf("t1 hold_acc_en %0d", i), bus.acc_en_out, 0);
      checkOutput($sformatf("t1 hold_done %0d", i), bus.done_out, 0);
    end
    finishJob("t1");

    // Three tiles, activation buffer empty for 10 cycles before tile 1
    $display("[TB] multi tile K=2 T=3");
    doneBase = doneSeen;
    applyStimulus(1'b1, 2, 3, 1'b1, 1'b0);
    waitIssue(2, "t2 issue_wait0");
    checkTileWindow(2, 0, -1);
    bus.act_tile_rdy_in = 1'b0;
    bus.out_ack_in      = 1'b1;
    nextCycle();
    bus.out_ack_in = 1'b0;
    checkOutput("t2 tile_idx1", bus.tile_idx_out, 1);
    checkOutput("t2 valid_drop", bus.out_valid_out, 0);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("t2 wait_rd_en %0d", i), bus.act_rd_en_out, 0);
      checkOutput($sformatf("t2 wait_busy %0d", i), bus.busy_out, 1);
      checkOutput($sformatf("t2 wait_tile %0d", i), bus.tile_idx_out, 1);
      checkOutput($sformatf("t2 wait_done %0d", i), bus.done_out, 0);
      nextCycle();
    end
    bus.act_tile_rdy_in = 1'b1;
    waitIssue(1, "t2 issue_wait1");
    checkTileWindow(2, 1, -1);
    bus.out_ack_in = 1'b1;
    nextCycle();
    bus.out_ack_in = 1'b0;
    checkOutput("t2 tile_idx2", bus.tile_idx_out, 2);
    waitIssue(1, "t2 issue_wait2");
    bus.out_ack_in = 1'b1;
    checkTileWindow(2, 2, -1);
    nextCycle();
    bus.out_ack_in = 1'b0;
    checkOutput("t2 done", bus.done_out, 1);
    checkOutput("t2 busy_after", bus.busy_out, 0);
    nextCycle();
    nextCycle();
    checkOutput("t2 done_count", doneSeen - doneBase, 1);

    // Zero step count runs one step with clear and enable coincident
    $display("[TB] k_len=0");
    applyStimulus(1'b1, 0, 1, 1'b1, 1'b0);
    waitIssue(2, "t3 issue_wait");
    checkTileWindow(1, 0, -1);
    finishJob("t3");

    // Zero tiles completes immediately without going busy
    $display("[TB] tiles=0");
    applyStimulus(1'b1, 5, 0, 1'b1, 1'b0);
    nextCycle();
    checkOutput("t4 done", bus.done_out, 1);
    checkOutput("t4 busy", bus.busy_out, 0);
    nextCycle();
    checkOutput("t4 done_cleared", bus.done_out, 0);
    checkIdleOutputs("t4 idle");

    // Asynchronous reset in the middle of streaming, then a clean job
    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 5, 1, 1'b1, 1'b0);
    waitIssue(2, "t5 issue_wait");
    nextCycle();
    checkOutput("t5 streaming", bus.act_rd_en_out, 1);
    #2;
    resetN = 1'b0;
    #1;
    checkIdleOutputs("t5 async");
    checkOutput("t5 async done", bus.done_out, 0);
    checkOutput("t5 async tile", bus.tile_idx_out, 0);
    nextCycle();
    resetN = 1'b1;
    nextCycle();
    applyStimulus(1'b1, 3, 1, 1'b1, 1'b0);
    waitIssue(2, "t5 issue_wait_after");
    checkTileWindow(3, 0, -1);
    finishJob("t5");

    // A start pulse during DRAIN with different settings is ignored
    $display("[TB] start during drain");
    applyStimulus(1'b1, 2, 1, 1'b1, 1'b0);
    waitIssue(2, "t6 issue_wait");
    checkTileWindow(2, 0, 3);
    finishJob("t6");
    checkIdleOutputs("t6 idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
